// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a load/store port
// sharing one synchronous single-port RAM; sub-word stores use read-modify-write.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [7:0]  f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [1:0]  d_off,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] F_WAIT = 3'd1;
  localparam logic [2:0] D_WAIT = 3'd2;
  localparam logic [2:0] RMW    = 3'd3;
  localparam logic [2:0] D_DONE = 3'd4;

  logic [2:0]  state, next_state;
  logic        last_f;
  logic [7:0]  addr_q;
  logic        we_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q;
  logic [31:0] f_hold, d_hold;
  logic        idle, grant_f, grant_d, word_store, d_load_valid;
  logic [3:0]  lane_mask;
  logic [31:0] wide_data, merged;

  // Grants are suppressed while rst is high so a reset cycle never starts an access.
  assign idle       = (state == IDLE);
  assign grant_f    = idle && !rst && f_req && (!d_req || !last_f);
  assign grant_d    = idle && !rst && d_req && (!f_req || last_f);
  assign word_store = grant_d && d_we && d_size[1];
  assign f_gnt      = grant_f;
  assign d_gnt      = grant_d;
  assign busy       = !idle;

  assign f_valid      = (state == F_WAIT) && !rst;
  assign d_valid      = ((state == D_WAIT) || (state == D_DONE)) && !rst;
  assign d_load_valid = (state == D_WAIT) && !we_q && !rst;
  assign f_rdata      = f_valid ? ram_dout : f_hold;
  assign d_rdata      = d_load_valid ? ram_dout : d_hold;

  // Store data is replicated across lanes so the lane mask alone selects what lands.
  always_comb begin
    lane_mask = 4'b0000;
    if (size_q == 2'b00) lane_mask[off_q] = 1'b1;
    else if (off_q[1])   lane_mask = 4'b1100;
    else                 lane_mask = 4'b0011;
    wide_data = (size_q == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
    merged = ram_dout;
    for (int i = 0; i < 4; i++)
      if (lane_mask[i]) merged[8*i +: 8] = wide_data[8*i +: 8];
  end

  always_comb begin
    ram_addr = addr_q;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (grant_f) begin
      ram_addr = f_addr;
    end else if (grant_d) begin
      ram_addr = d_addr;
      if (word_store) begin
        ram_we  = 1'b1;
        ram_din = d_wdata;
      end
    end else if (state == RMW && !rst) begin
      ram_we  = 1'b1;
      ram_din = merged;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (grant_f)      next_state = F_WAIT;
        else if (grant_d) next_state = (d_we && !d_size[1]) ? RMW : D_WAIT;
      end
      RMW:     next_state = D_DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_f  <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      f_hold  <= '0;
      d_hold  <= '0;
    end else begin
      state <= next_state;
      if (grant_f) begin
        last_f <= 1'b1;
        addr_q <= f_addr;
      end else if (grant_d) begin
        last_f  <= 1'b0;
        addr_q  <= d_addr;
        we_q    <= d_we;
        size_q  <= d_size;
        off_q   <= d_off;
        wdata_q <= d_wdata;
      end
      if (f_valid)      f_hold <= ram_dout;
      if (d_load_valid) d_hold <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model that tracks arbitration, latency and a shadow copy of RAM.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_valid;
  logic [7:0]  f_addr;
  logic [31:0] f_rdata;
  logic        d_req, d_we, d_gnt, d_valid;
  logic [7:0]  d_addr;
  logic [1:0]  d_off, d_size;
  logic [31:0] d_wdata, d_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din, ram_dout;
  logic        busy;

  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic        preWe;
  logic [7:0]  preAddr;
  logic [31:0] preData;
  int tests = 0;
  int fails = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_off(d_off), .d_size(d_size),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we)     mem[ram_addr] <= ram_din;
    else if (preWe) mem[preAddr] <= preData;
    ram_dout <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mergeRef(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    int base;
    r = old;
    if (sz == 2'b00) r[8*off +: 8] = wd[7:0];
    else begin
      base = (off >= 2) ? 16 : 0;
      r[base +: 16] = wd[15:0];
    end
    return r;
  endfunction

  // Reference model: busyLeft counts busy cycles left in the current access.
  int          busyLeft = 0;
  int          pKind = 0;
  bit          lastF = 1'b1;
  logic [7:0]  pAddr;
  logic [31:0] pData, pWdata, mw;
  logic [1:0]  pSize, pOff;
  logic [31:0] lastFData = '0;
  logic [31:0] lastDData = '0;
  bit          eF, eD, wStore, rmwNow, vF, vD;

  always @(negedge clk) begin
    eF = 1'b0;
    eD = 1'b0;
    if (!rst && busyLeft == 0) begin
      if (f_req && d_req) begin
        eD = lastF;
        eF = !lastF;
      end else begin
        eF = f_req;
        eD = d_req;
      end
    end
    wStore = eD && d_we && d_size[1];
    rmwNow = !rst && busyLeft == 2 && pKind == 3;
    vF = !rst && busyLeft == 1 && pKind == 0;
    vD = !rst && busyLeft == 1 && pKind != 0;
    if (vF) lastFData = pData;
    if (vD && pKind == 1) lastDData = pData;
    checkOutput("f_gnt", f_gnt, eF);
    checkOutput("d_gnt", d_gnt, eD);
    checkOutput("busy", busy, busyLeft != 0);
    checkOutput("f_valid", f_valid, vF);
    checkOutput("d_valid", d_valid, vD);
    checkOutput("f_rdata", f_rdata, lastFData);
    checkOutput("d_rdata", d_rdata, lastDData);
    checkOutput("ram_we", ram_we, wStore || rmwNow);
    if (eF) checkOutput("ram_addr_f", ram_addr, f_addr);
    if (eD) checkOutput("ram_addr_d", ram_addr, d_addr);
    if (wStore) checkOutput("ram_din_word", ram_din, d_wdata);
    if (rmwNow) begin
      mw = mergeRef(shadow[pAddr], pWdata, pSize, pOff);
      checkOutput("ram_addr_rmw", ram_addr, pAddr);
      checkOutput("ram_din_rmw", ram_din, mw);
    end
    if (preWe) shadow[preAddr] = preData;
    if (rst) begin
      busyLeft  = 0;
      lastF     = 1'b1;
      lastFData = '0;
      lastDData = '0;
    end else if (busyLeft > 0) begin
      if (rmwNow) shadow[pAddr] = mw;
      busyLeft--;
    end else if (eF || eD) begin
      lastF  = eF;
      pAddr  = eF ? f_addr : d_addr;
      pKind  = eF ? 0 : (!d_we ? 1 : (d_size[1] ? 2 : 3));
      pData  = shadow[pAddr];
      pWdata = d_wdata;
      pSize  = d_size;
      pOff   = d_off;
      busyLeft = (pKind == 3) ? 2 : 1;
      if (pKind == 2) shadow[pAddr] = d_wdata;
    end
  end

  task automatic applyStimulus(input logic fr, input logic [7:0] fa, input logic dr, input logic dwe,
                               input logic [7:0] da, input logic [1:0] doff, input logic [1:0] dsz,
                               input logic [31:0] dwd);
    f_req = fr; f_addr = fa;
    d_req = dr; d_we = dwe; d_addr = da; d_off = doff; d_size = dsz; d_wdata = dwd;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    preWe = 1'b1; preAddr = a; preData = v;
    @(posedge clk); #1;
    preWe = 1'b0;
  endtask

  task automatic waitGnt(input string tag, input bit wantF);
    int n = 0;
    @(negedge clk);
    while (!(wantF ? f_gnt : d_gnt) && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_grant_in_time"}, n < 20, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic fG, dG;
    rst = 1'b1; preWe = 1'b0; preAddr = '0; preData = '0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 2'd0, 2'd0, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);

    @(negedge clk);
    checkOutput("rst_f_gnt", f_gnt, 0);
    checkOutput("rst_d_gnt", d_gnt, 0);
    checkOutput("rst_f_valid", f_valid, 0);
    checkOutput("rst_d_valid", d_valid, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_f_rdata", f_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_ram_din", ram_din, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);

    // Single fetch
    @(posedge clk); #1;
    rst = 1'b0;
    preload(8'h10, 32'hDEADBEEF);
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 2'd0, 2'd0, 32'h0);
    waitGnt("fetch", 1);
    checkOutput("fetch_busy_T", busy, 0);
    checkOutput("fetch_addr_T", ram_addr, 8'h10);
    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    checkOutput("fetch_valid_T1", f_valid, 1);
    checkOutput("fetch_rdata_T1", f_rdata, 32'hDEADBEEF);
    checkOutput("fetch_busy_T1", busy, 1);
    @(negedge clk);
    checkOutput("fetch_busy_T2", busy, 0);
    checkOutput("fetch_rdata_hold", f_rdata, 32'hDEADBEEF);

    // Tie from reset release: data first, then alternation
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1, 8'h30, 1, 0, 8'h20, 2'd0, 2'd0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      @(negedge clk);
      checkOutput($sformatf("tie%0d_d_gnt", k), d_gnt, (k % 2) == 0);
      checkOutput($sformatf("tie%0d_f_gnt", k), f_gnt, (k % 2) == 1);
    end
    @(posedge clk); #1;
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Byte store with inputs changed right after grant
    @(posedge clk); #1;
    preload(8'h05, 32'h11223344);
    applyStimulus(0, 8'h00, 1, 1, 8'h05, 2'd2, 2'b00, 32'h123456AB);
    waitGnt("bstore", 0);
    @(posedge clk); #1;
    d_req = 1'b0; d_wdata = 32'hFFFFFFFF; d_off = 2'd0; d_size = 2'b10;
    @(negedge clk);
    checkOutput("bstore_valid_T1", d_valid, 0);
    @(negedge clk);
    checkOutput("bstore_valid_T2", d_valid, 1);
    @(posedge clk); #1;
    checkOutput("bstore_mem", mem[8'h05], 32'h11AB3344);

    // Half store, offset 3
    preload(8'h06, 32'h11223344);
    applyStimulus(0, 8'h00, 1, 1, 8'h06, 2'd3, 2'b01, 32'h0000BEEF);
    waitGnt("hstore", 0);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("hstore_valid_T2", d_valid, 1);
    @(posedge clk); #1;
    checkOutput("hstore_mem", mem[8'h06], 32'hBEEF3344);

    // Word store
    applyStimulus(0, 8'h00, 1, 1, 8'h07, 2'd0, 2'b10, 32'hCAFEF00D);
    waitGnt("wstore", 0);
    checkOutput("wstore_we_T", ram_we, 1);
    checkOutput("wstore_din_T", ram_din, 32'hCAFEF00D);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("wstore_valid_T1", d_valid, 1);
    @(posedge clk); #1;
    checkOutput("wstore_mem", mem[8'h07], 32'hCAFEF00D);

    // Reset during the RMW cycle of a byte store
    preload(8'h05, 32'h11223344);
    applyStimulus(0, 8'h00, 1, 1, 8'h05, 2'd2, 2'b00, 32'h000000AB);
    waitGnt("abort", 0);
    @(posedge clk); #1;
    d_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_we_rmw", ram_we, 0);
    checkOutput("abort_valid_rmw", d_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_d_valid", d_valid, 0);
    checkOutput("abort_ram_addr", ram_addr, 0);
    checkOutput("abort_ram_din", ram_din, 0);
    checkOutput("abort_d_rdata", d_rdata, 0);
    checkOutput("abort_mem", mem[8'h05], 32'h11223344);

    // Random traffic on a small address window, with occasional resets
    @(posedge clk); #1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      fG = f_gnt;
      dG = d_gnt;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 49) == 0);
      if (!f_req || fG) begin
        f_req  = 1'($urandom_range(0, 1));
        f_addr = 8'($urandom_range(0, 15));
      end
      if (!d_req || dG) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 8'($urandom_range(0, 15));
        d_off   = 2'($urandom);
        d_size  = 2'($urandom);
        d_wdata = $urandom;
      end
    end
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) checkOutput($sformatf("mem_%0d", i), mem[i], shadow[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first, one per line:
  clk  input  1  single clock; all state updates on rising edge
  rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
  f_req  input  1  instruction-fetch request, held until f_gnt
  f_addr  input  8  fetch word address
  f_gnt  output  1  fetch grant, one-cycle pulse
  f_valid  output  1  fetch data valid, one-cycle pulse
  f_rdata  output  32  fetch read word
  d_req  input  1  load/store request, held until d_gnt
  d_we  input  1  1 = store, 0 = load
  d_addr  input  8  data word address
  d_off  input  2  byte offset within word (stores only)
  d_size  input  2  00 byte, 01 half, 10/11 word
  d_wdata  input  32  store data, right-aligned
  d_gnt  output  1  data grant, one-cycle pulse
  d_valid  output  1  load data valid or store complete, one-cycle pulse
  d_rdata  output  32  load read word, unextended
  ram_addr  output  8  RAM word address
  ram_we  output  1  RAM write enable
  ram_din  output  32  RAM write word
  ram_dout  input  32  RAM read word, valid one cycle after address
  busy  output  1  high in every state except IDLE
REQ-002 There SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-003 The FSM SHALL have the states IDLE, F_WAIT, D_WAIT, RMW and D_DONE.
REQ-004 Requests SHALL be arbitrated in IDLE only; at most one grant SHALL be given per cycle.
REQ-005 With one request pending, that requester SHALL be granted.
REQ-006 With both requests pending, the port not granted last SHALL win (round-robin); the last-grant flag SHALL reset to "fetch", so data wins the first tie.
REQ-007 In the grant cycle, ram_addr SHALL equal the granted address, driven combinationally; the address SHALL also be latched for later states.
REQ-008 Fetch or load: grant cycle T presents the address; at T+1 (F_WAIT/D_WAIT) f_rdata/d_rdata SHALL capture ram_dout with f_valid/d_valid high for exactly that cycle; the FSM SHALL then go to IDLE.
REQ-009 Word store (d_size 1x): ram_we=1 and ram_din=d_wdata in the grant cycle; d_valid=1 at T+1 (D_WAIT), then IDLE.
REQ-010 Sub-word store: grant cycle T presents a read; at T+1 (RMW) the block SHALL merge ram_dout with d_wdata and write the result to the latched address with ram_we=1.
REQ-011 At T+2 (D_DONE) of a sub-word store, d_valid SHALL be 1, then IDLE.
REQ-012 Merge, byte: lane d_off receives d_wdata[7:0].
REQ-013 Merge, half: lanes {d_off[1],1} and {d_off[1],0} receive d_wdata[15:0]; d_off[0] SHALL be ignored.
REQ-014 Merge: all other lanes SHALL keep the ram_dout value.
REQ-015 Store data, size and offset SHALL be latched at grant; later input changes SHALL have no effect.
REQ-016 A request arriving while busy=1 SHALL wait; it is considered in the first cycle back in IDLE, so back-to-back reads occur every 2 cycles.
REQ-017 f_rdata and d_rdata SHALL hold their last value between valid pulses.
REQ-018 ram_we SHALL be 0 in IDLE without a word-store grant, and in F_WAIT, D_WAIT and D_DONE.

Reset
REQ-019 With rst=1 at a clock edge, next state SHALL be IDLE.
REQ-020 After that edge: f_gnt, d_gnt, f_valid, d_valid, ram_we and busy SHALL be 0; f_rdata, d_rdata, ram_din and ram_addr SHALL be 0; the last-grant flag SHALL be "fetch".
REQ-021 Reset mid-operation SHALL abort the access with no valid pulse; a pending RMW write SHALL NOT be issued.

Verification
REQ-022 Fetch only: RAM[0x10]=0xDEADBEEF, f_req with f_addr=0x10 -> f_gnt at T, f_valid with f_rdata=0xDEADBEEF at T+1, busy high only at T+1.
REQ-023 Tie: f_req and d_req (load 0x20) both high from reset release -> d_gnt first, then f_gnt two cycles later; repeated ties alternate grants.
REQ-024 Byte store: RAM[0x05]=0x11223344, d_size=00, d_off=2, d_wdata=0xAB -> RAM[0x05]=0x11AB3344 and d_valid at T+2.
REQ-025 Half store: RAM[0x06]=0x11223344, d_size=01, d_off=3, d_wdata=0xBEEF -> RAM[0x06]=0xBEEF3344; word store 0xCAFEF00D to 0x07 -> written at T, d_valid at T+1.
REQ-026 Reset during RMW state of a byte store to 0x05 -> RAM[0x05] unchanged, no d_valid, all outputs at reset values the next cycle.
